axi_ram_rd_if: RTL and testbench

//  AXI4 RAM read interface. Accepts AR bursts and issues one RAM read command per beat.

---
 rtl/axi_ram_pkg.sv | 25 ++
 rtl/axi_ram_rd_if_if.sv | 82 ++++++++
 rtl/axi_ram_rd_skid.sv | 56 +++++
 rtl/axi_ram_rd_if.sv | 148 ++++++++++++++
 tb/tb_axi_ram_rd_if.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ram_pkg.sv
// Shared definitions for the AXI RAM read/write interfaces: burst and response
// encodings, the read-side FSM state type and the WRAP address mask helper.
package axi_ram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } rd_state_t;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats; other lengths fall back to INCR.
    function automatic logic is_wrap_len(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Mask covering the low address bits that cycle within one wrap window.
    function automatic logic [31:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
        return (({24'd0, len} + 32'd1) << size) - 32'd1;
    endfunction

endpackage

// File: rtl/axi_ram_rd_if_if.sv
// Bundle of the AXI read slave port (AR/R) and the RAM read command/response port.
// The slave modport is the view of axi_ram_rd_if; master is the view of its environment.
interface axi_ram_rd_if_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int ID_WIDTH     = 8,
    parameter int ARUSER_WIDTH = 1,
    parameter int RUSER_WIDTH  = 1
);
    logic [ID_WIDTH-1:0]     s_axi_arid;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [7:0]              s_axi_arlen;
    logic [2:0]              s_axi_arsize;
    logic [1:0]              s_axi_arburst;
    logic                    s_axi_arlock;
    logic [3:0]              s_axi_arcache;
    logic [2:0]              s_axi_arprot;
    logic [3:0]              s_axi_arqos;
    logic [3:0]              s_axi_arregion;
    logic [ARUSER_WIDTH-1:0] s_axi_aruser;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;

    logic [ID_WIDTH-1:0]     s_axi_rid;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rlast;
    logic [RUSER_WIDTH-1:0]  s_axi_ruser;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    logic [ID_WIDTH-1:0]     ram_rd_cmd_id;
    logic [ADDR_WIDTH-1:0]   ram_rd_cmd_addr;
    logic                    ram_rd_cmd_lock;
    logic [3:0]              ram_rd_cmd_cache;
    logic [2:0]              ram_rd_cmd_prot;
    logic [3:0]              ram_rd_cmd_qos;
    logic [3:0]              ram_rd_cmd_region;
    logic [ARUSER_WIDTH-1:0] ram_rd_cmd_auser;
    logic                    ram_rd_cmd_last;
    logic                    ram_rd_cmd_en;
    logic                    ram_rd_cmd_ready;

    logic [ID_WIDTH-1:0]     ram_rd_resp_id;
    logic [DATA_WIDTH-1:0]   ram_rd_resp_data;
    logic                    ram_rd_resp_last;
    logic [RUSER_WIDTH-1:0]  ram_rd_resp_user;
    logic                    ram_rd_resp_valid;
    logic                    ram_rd_resp_ready;

    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion,
               s_axi_aruser, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid,
        input  s_axi_rready,
        output ram_rd_cmd_id, ram_rd_cmd_addr, ram_rd_cmd_lock, ram_rd_cmd_cache,
               ram_rd_cmd_prot, ram_rd_cmd_qos, ram_rd_cmd_region, ram_rd_cmd_auser,
               ram_rd_cmd_last, ram_rd_cmd_en,
        input  ram_rd_cmd_ready,
        input  ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last, ram_rd_resp_user,
               ram_rd_resp_valid,
        output ram_rd_resp_ready
    );

    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion,
               s_axi_aruser, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid,
        output s_axi_rready,
        input  ram_rd_cmd_id, ram_rd_cmd_addr, ram_rd_cmd_lock, ram_rd_cmd_cache,
               ram_rd_cmd_prot, ram_rd_cmd_qos, ram_rd_cmd_region, ram_rd_cmd_auser,
               ram_rd_cmd_last, ram_rd_cmd_en,
        output ram_rd_cmd_ready,
        output ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last, ram_rd_resp_user,
               ram_rd_resp_valid,
        input  ram_rd_resp_ready
    );
endinterface

// File: rtl/axi_ram_rd_skid.sv
// Two-entry ready/valid skid buffer: an output register plus one overflow slot.
// in_ready depends only on flops (and reset), so it breaks the ready path.
module axi_ram_rd_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] out_data_p0;
    logic [WIDTH-1:0] skid_data_p0;
    logic             out_vld_p0;
    logic             skid_vld_p0;
    logic             push;
    logic             load;

    assign in_ready  = !skid_vld_p0 && !rst;
    assign push      = in_valid && in_ready;
    assign load      = !out_vld_p0 || out_ready;
    assign out_data  = out_data_p0;
    assign out_valid = out_vld_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_p0  <= 1'b0;
            skid_vld_p0 <= 1'b0;
            out_data_p0 <= '0;
        end else if (skid_vld_p0) begin
            if (load) begin
                out_vld_p0  <= 1'b1;
                out_data_p0 <= skid_data_p0;
                skid_vld_p0 <= 1'b0;
            end
        end else if (push) begin
            if (load) begin
                out_vld_p0  <= 1'b1;
                out_data_p0 <= in_data;
            end else begin
                skid_vld_p0 <= 1'b1;
            end
        end else if (load) begin
            out_vld_p0 <= 1'b0;
        end
    end

    // Overflow slot only fills when the output register is stalled.
    always_ff @(posedge clk) begin
        if (push && !load) skid_data_p0 <= in_data;
    end

endmodule

// File: rtl/axi_ram_rd_if.sv
// AXI4 RAM read interface: expands AR bursts into one RAM read command per beat and
// returns RAM responses on the R channel through a 2-entry skid buffer.
module axi_ram_rd_if
    import axi_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter bit ARUSER_ENABLE = 1'b0,
    parameter int ARUSER_WIDTH  = 1,
    parameter bit RUSER_ENABLE  = 1'b0,
    parameter int RUSER_WIDTH   = 1
) (
    input logic              clk,
    input logic              rst,
    axi_ram_rd_if_if.slave   bus
);
    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));
    localparam int         SKID_W   = ID_WIDTH + DATA_WIDTH + 1 + RUSER_WIDTH;

    rd_state_t               state;
    logic                    arready_r;
    logic                    cmd_en_r;
    logic                    last_r;
    logic [7:0]              count;
    logic [7:0]              len_r;
    logic [2:0]              size_r;
    logic [1:0]              burst_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [ADDR_WIDTH-1:0]   step;
    logic [ADDR_WIDTH-1:0]   mask;
    logic [ID_WIDTH-1:0]     id_r;
    logic                    lock_r;
    logic [3:0]              cache_r;
    logic [2:0]              prot_r;
    logic [3:0]              qos_r;
    logic [3:0]              region_r;
    logic [ARUSER_WIDTH-1:0] auser_r;
    logic [2:0]              size_clamped;
    logic                    ar_hs;
    logic                    cmd_hs;

    assign ar_hs        = bus.s_axi_arvalid && arready_r;
    assign cmd_hs       = cmd_en_r && bus.ram_rd_cmd_ready;
    assign size_clamped = (bus.s_axi_arsize > SIZE_MAX) ? SIZE_MAX : bus.s_axi_arsize;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_r;
        mask      = ADDR_WIDTH'(wrap_mask(len_r, size_r));
        addr_next = addr_r + step;
        case (burst_r)
            BURST_FIXED: addr_next = addr_r;
            BURST_WRAP:  if (is_wrap_len(len_r)) addr_next = (addr_r & ~mask) | ((addr_r + step) & mask);
            default:     addr_next = addr_r + step;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            arready_r <= 1'b0;
            cmd_en_r  <= 1'b0;
            last_r    <= 1'b0;
            count     <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        arready_r <= 1'b0;
                        cmd_en_r  <= 1'b1;
                        count     <= bus.s_axi_arlen;
                        last_r    <= (bus.s_axi_arlen == 8'd0);
                        state     <= ST_BURST;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (cmd_hs) begin
                        if (last_r) begin
                            cmd_en_r  <= 1'b0;
                            arready_r <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            count  <= count - 8'd1;
                            last_r <= (count == 8'd1);
                        end
                    end
                end
            endcase
        end
    end

    // Burst attributes and the running beat address.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            addr_r   <= bus.s_axi_araddr;
            len_r    <= bus.s_axi_arlen;
            size_r   <= size_clamped;
            burst_r  <= bus.s_axi_arburst;
            id_r     <= bus.s_axi_arid;
            lock_r   <= bus.s_axi_arlock;
            cache_r  <= bus.s_axi_arcache;
            prot_r   <= bus.s_axi_arprot;
            qos_r    <= bus.s_axi_arqos;
            region_r <= bus.s_axi_arregion;
            auser_r  <= bus.s_axi_aruser;
        end else if (cmd_hs) begin
            addr_r <= addr_next;
        end
    end

    assign bus.s_axi_arready     = arready_r;
    assign bus.ram_rd_cmd_en     = cmd_en_r;
    assign bus.ram_rd_cmd_last   = last_r;
    assign bus.ram_rd_cmd_addr   = addr_r;
    assign bus.ram_rd_cmd_id     = id_r;
    assign bus.ram_rd_cmd_lock   = lock_r;
    assign bus.ram_rd_cmd_cache  = cache_r;
    assign bus.ram_rd_cmd_prot   = prot_r;
    assign bus.ram_rd_cmd_qos    = qos_r;
    assign bus.ram_rd_cmd_region = region_r;
    assign bus.ram_rd_cmd_auser  = ARUSER_ENABLE ? auser_r : '0;

    logic [RUSER_WIDTH-1:0] resp_user;
    logic [SKID_W-1:0]      skid_in;
    logic [SKID_W-1:0]      skid_out;

    assign resp_user = RUSER_ENABLE ? bus.ram_rd_resp_user : '0;
    assign skid_in   = {bus.ram_rd_resp_id, bus.ram_rd_resp_data, bus.ram_rd_resp_last, resp_user};

    axi_ram_rd_skid #(.WIDTH(SKID_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (skid_in),
        .in_valid  (bus.ram_rd_resp_valid),
        .in_ready  (bus.ram_rd_resp_ready),
        .out_data  (skid_out),
        .out_valid (bus.s_axi_rvalid),
        .out_ready (bus.s_axi_rready)
    );

    assign {bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rlast, bus.s_axi_ruser} = skid_out;
    assign bus.s_axi_rresp = RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_rd_if.sv
// Bench for axi_ram_rd_if: directed burst/backpressure/reset scenarios plus a randomized
// run against a queue-based model of burst addressing and in-order response delivery.
module tb_axi_ram_rd_if;
    import axi_ram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_ram_rd_if_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8),
                       .ARUSER_WIDTH(1), .RUSER_WIDTH(1)) bus ();

    axi_ram_rd_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] obs_addr[$];
    logic        obs_last[$];

    typedef struct { logic [15:0] addr; logic last; logic [7:0] id; } beat_t;
    typedef struct { logic [7:0] id; logic [31:0] data; logic last; } rsp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address of beat i, computed from the AXI burst rules on plain integers.
    function automatic logic [15:0] exp_addr(input logic [15:0] base, input logic [7:0] len,
                                             input logic [2:0] sz, input logic [1:0] bt, input int i);
        int s, step, total, b;
        s    = (sz > 3'd2) ? 2 : int'(sz);
        step = 1 << s;
        b    = int'(base);
        if (bt == 2'b00) return base;
        if (bt == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            total = (int'(len) + 1) * step;
            return 16'((b - (b % total)) + (((b % total) + i * step) % total));
        end
        return 16'((b + i * step) % 65536);
    endfunction

    task automatic init_inputs();
        bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
        bus.s_axi_arsize = '0; bus.s_axi_arburst = '0; bus.s_axi_arlock = '0;
        bus.s_axi_arcache = '0; bus.s_axi_arprot = '0; bus.s_axi_arqos = '0;
        bus.s_axi_arregion = '0; bus.s_axi_aruser = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0; bus.ram_rd_cmd_ready = 1'b0;
        bus.ram_rd_resp_id = '0; bus.ram_rd_resp_data = '0; bus.ram_rd_resp_last = 1'b0;
        bus.ram_rd_resp_user = '0; bus.ram_rd_resp_valid = 1'b0;
    endtask

    // Issues one AR and records every accepted command beat; to=1 if a bound expired.
    task automatic collect_burst(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz,
                                 input logic [1:0] bt, input int rdy_pct, output bit to);
        int  w;
        bit  done;
        obs_addr.delete();
        obs_last.delete();
        to = 1'b0;
        bus.s_axi_araddr = a; bus.s_axi_arlen = len; bus.s_axi_arsize = sz;
        bus.s_axi_arburst = bt; bus.s_axi_arvalid = 1'b1;
        w = 0;
        while (!bus.s_axi_arready && w < 50) begin tick(); w++; end
        if (w >= 50) begin to = 1'b1; bus.s_axi_arvalid = 1'b0; return; end
        tick();
        bus.s_axi_arvalid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            bus.ram_rd_cmd_ready = ($urandom_range(0, 99) < rdy_pct);
            if (bus.ram_rd_cmd_en && bus.ram_rd_cmd_ready) begin
                obs_addr.push_back(bus.ram_rd_cmd_addr);
                obs_last.push_back(bus.ram_rd_cmd_last);
                if (bus.ram_rd_cmd_last) done = 1'b1;
            end
            tick();
        end
        bus.ram_rd_cmd_ready = 1'b0;
        if (!done) to = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_inputs();
        repeat (3) tick();
        n_tests++; if (bus.s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %b want 0", bus.s_axi_arready); end
        n_tests++; if (bus.ram_rd_cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_en: got %b want 0", bus.ram_rd_cmd_en); end
        n_tests++; if (bus.s_axi_rvalid !== 1'b0 || bus.s_axi_rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_rlast: got %b%b want 00", bus.s_axi_rvalid, bus.s_axi_rlast); end
        n_tests++; if (bus.s_axi_rid !== 8'h00 || bus.s_axi_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rid_rdata: got %h/%h want 00/0", bus.s_axi_rid, bus.s_axi_rdata); end
        n_tests++; if (bus.ram_rd_resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ready: got %b want 0", bus.ram_rd_resp_ready); end
        rst = 1'b0;
        #1;
        n_tests++; if (bus.ram_rd_resp_ready !== 1'b1) begin n_fail++; $display("FAIL release_resp_ready: got %b want 1", bus.ram_rd_resp_ready); end
        n_tests++; if (bus.s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL release_arready_early: got %b want 0", bus.s_axi_arready); end
        tick();
        n_tests++; if (bus.s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL release_arready: got %b want 1", bus.s_axi_arready); end
    endtask

    task automatic test_incr();
        logic [15:0] exp;
        bus.ram_rd_cmd_ready = 1'b1;
        bus.s_axi_arid = 8'h5A; bus.s_axi_arprot = 3'd5; bus.s_axi_araddr = 16'h0100;
        bus.s_axi_arlen = 8'd3; bus.s_axi_arsize = 3'd2; bus.s_axi_arburst = BURST_INCR;
        bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_arvalid = 1'b0;
        n_tests++; if (bus.s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL incr_arready_drop: got %b want 0", bus.s_axi_arready); end
        n_tests++; if (bus.ram_rd_cmd_id !== 8'h5A || bus.ram_rd_cmd_prot !== 3'd5) begin n_fail++; $display("FAIL incr_attr: got id %h prot %0d want 5a 5", bus.ram_rd_cmd_id, bus.ram_rd_cmd_prot); end
        for (int i = 0; i < 4; i++) begin
            exp = 16'h0100 + 16'(4 * i);
            n_tests++;
            if (bus.ram_rd_cmd_en !== 1'b1 || bus.ram_rd_cmd_addr !== exp || bus.ram_rd_cmd_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL incr_beat%0d: got en %b addr %h last %b want 1 %h %b", i,
                         bus.ram_rd_cmd_en, bus.ram_rd_cmd_addr, bus.ram_rd_cmd_last, exp, (i == 3));
            end
            tick();
        end
        n_tests++; if (bus.ram_rd_cmd_en !== 1'b0 || bus.s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL incr_end: got en %b arready %b want 0 1", bus.ram_rd_cmd_en, bus.s_axi_arready); end
        bus.ram_rd_cmd_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bit to;
        logic [15:0] exp[4];
        exp = '{16'h0038, 16'h003C, 16'h0030, 16'h0034};
        collect_burst(16'h0038, 8'd3, 3'd2, BURST_WRAP, 60, to);
        n_tests++; if (to || obs_addr.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d beats timeout %b want 4 0", obs_addr.size(), to); end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            n_tests++;
            if (obs_addr[i] !== exp[i] || obs_last[i] !== (i == 3)) begin
                n_fail++; $display("FAIL wrap_beat%0d: got %h/%b want %h/%b", i, obs_addr[i], obs_last[i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_fixed();
        bit to;
        collect_burst(16'h0010, 8'd2, 3'd2, BURST_FIXED, 50, to);
        n_tests++; if (to || obs_addr.size() != 3) begin n_fail++; $display("FAIL fixed_count: got %0d beats timeout %b want 3 0", obs_addr.size(), to); end
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            n_tests++;
            if (obs_addr[i] !== 16'h0010 || obs_last[i] !== (i == 2)) begin
                n_fail++; $display("FAIL fixed_beat%0d: got %h/%b want 0010/%b", i, obs_addr[i], obs_last[i], (i == 2));
            end
        end
    endtask

    task automatic test_clamp_reserved();
        bit to;
        collect_burst(16'h0200, 8'd1, 3'd3, BURST_INCR, 100, to);
        n_tests++; if (to || obs_addr.size() != 2 || obs_addr[0] !== 16'h0200 || obs_addr[1] !== 16'h0204) begin
            n_fail++; $display("FAIL clamp_step: got n=%0d timeout %b want 0200,0204", obs_addr.size(), to);
        end
        collect_burst(16'h0300, 8'd2, 3'd1, 2'b11, 100, to);
        n_tests++; if (to || obs_addr.size() != 3 || obs_addr[2] !== 16'h0304 || obs_last[2] !== 1'b1) begin
            n_fail++; $display("FAIL reserved_incr: got n=%0d timeout %b want 3 beats ending 0304", obs_addr.size(), to);
        end
        collect_burst(16'hFFFC, 8'd1, 3'd2, BURST_INCR, 100, to);
        n_tests++; if (to || obs_addr.size() != 2 || obs_addr[1] !== 16'h0000) begin
            n_fail++; $display("FAIL incr_carry: got n=%0d timeout %b want FFFC,0000", obs_addr.size(), to);
        end
    endtask

    task automatic test_r_backpressure();
        rsp_t r[4];
        int   idx, got;
        logic [7:0]  gid[4];
        logic [31:0] gdat[4];
        logic        glast[4];
        bit   hs;
        for (int k = 0; k < 4; k++) r[k] = '{id: 8'(8'h10 + k), data: 32'hA000_0000 + 32'(k * 17), last: (k == 3)};
        bus.s_axi_rready = 1'b0;
        idx = 0;
        bus.ram_rd_resp_id = r[0].id; bus.ram_rd_resp_data = r[0].data; bus.ram_rd_resp_last = r[0].last;
        bus.ram_rd_resp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            hs = bus.ram_rd_resp_ready;
            tick();
            if (hs) begin
                idx++;
                bus.ram_rd_resp_id = r[idx].id; bus.ram_rd_resp_data = r[idx].data; bus.ram_rd_resp_last = r[idx].last;
            end
        end
        n_tests++; if (idx != 2 || bus.ram_rd_resp_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got %0d accepted ready %b want 2 0", idx, bus.ram_rd_resp_ready); end
        n_tests++; if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rdata !== r[0].data || bus.s_axi_rid !== r[0].id) begin
            n_fail++; $display("FAIL bp_hold: got v%b %h/%h want 1 %h/%h", bus.s_axi_rvalid, bus.s_axi_rid, bus.s_axi_rdata, r[0].id, r[0].data);
        end
        bus.s_axi_rready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            if (bus.s_axi_rvalid) begin
                gid[got] = bus.s_axi_rid; gdat[got] = bus.s_axi_rdata; glast[got] = bus.s_axi_rlast;
                n_tests++; if (bus.s_axi_rresp !== RESP_OKAY) begin n_fail++; $display("FAIL bp_rresp: got %b want 00", bus.s_axi_rresp); end
                got++;
            end
            hs = bus.ram_rd_resp_valid && bus.ram_rd_resp_ready;
            tick();
            if (hs) begin
                idx++;
                if (idx < 4) begin
                    bus.ram_rd_resp_id = r[idx].id; bus.ram_rd_resp_data = r[idx].data; bus.ram_rd_resp_last = r[idx].last;
                end else begin
                    bus.ram_rd_resp_valid = 1'b0;
                end
            end
        end
        n_tests++; if (got != 4) begin n_fail++; $display("FAIL bp_delivered: got %0d want 4", got); end
        for (int k = 0; k < got; k++) begin
            n_tests++;
            if (gid[k] !== r[k].id || gdat[k] !== r[k].data || glast[k] !== r[k].last) begin
                n_fail++; $display("FAIL bp_order%0d: got %h/%h/%b want %h/%h/%b", k, gid[k], gdat[k], glast[k], r[k].id, r[k].data, r[k].last);
            end
        end
        bus.s_axi_rready = 1'b0;
        bus.ram_rd_resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        bus.ram_rd_cmd_ready = 1'b1;
        bus.s_axi_rready = 1'b0;
        bus.s_axi_araddr = 16'h0080; bus.s_axi_arlen = 8'd7; bus.s_axi_arsize = 3'd2;
        bus.s_axi_arburst = BURST_INCR; bus.s_axi_arvalid = 1'b1;
        bus.ram_rd_resp_data = 32'hDEAD_BEEF; bus.ram_rd_resp_valid = 1'b1;
        tick();
        bus.s_axi_arvalid = 1'b0;
        bus.ram_rd_resp_valid = 1'b0;
        tick();
        n_tests++; if (bus.ram_rd_cmd_en !== 1'b1 || bus.ram_rd_cmd_addr !== 16'h0084 || bus.s_axi_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got en %b addr %h rvalid %b want 1 0084 1", bus.ram_rd_cmd_en, bus.ram_rd_cmd_addr, bus.s_axi_rvalid);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (bus.ram_rd_cmd_en !== 1'b0 || bus.s_axi_rvalid !== 1'b0 || bus.s_axi_arready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_drop: got en %b rvalid %b arready %b want 0 0 0", bus.ram_rd_cmd_en, bus.s_axi_rvalid, bus.s_axi_arready);
        end
        bus.ram_rd_cmd_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        collect_burst(16'h0040, 8'd0, 3'd2, BURST_INCR, 100, to);
        n_tests++; if (to || obs_addr.size() != 1 || obs_addr[0] !== 16'h0040 || obs_last[0] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_next: got n=%0d timeout %b want one beat 0040 last", obs_addr.size(), to);
        end
        n_tests++; if (bus.s_axi_arready !== 1'b1 || bus.s_axi_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clean: got arready %b rvalid %b want 1 0", bus.s_axi_arready, bus.s_axi_rvalid);
        end
    endtask

    task automatic test_random();
        localparam int NB = 40;
        beat_t exp_cmd[$];
        rsp_t  pend[$];
        rsp_t  exp_r[$];
        beat_t e;
        rsp_t  rr, p;
        int    sent, total, rcount, cyc, pick;
        bit    ar_hs, resp_hs, prev_stall, done;
        logic [7:0]  prev_id;
        logic [31:0] prev_data;
        logic        prev_last;
        sent = 0; total = 0; rcount = 0; prev_stall = 1'b0; done = 1'b0;
        init_inputs();
        for (cyc = 0; cyc < 20000 && !done; cyc++) begin
            ar_hs = bus.s_axi_arvalid && bus.s_axi_arready;
            if (ar_hs) begin
                for (int i = 0; i <= int'(bus.s_axi_arlen); i++)
                    exp_cmd.push_back('{addr: exp_addr(bus.s_axi_araddr, bus.s_axi_arlen, bus.s_axi_arsize, bus.s_axi_arburst, i),
                                        last: (i == int'(bus.s_axi_arlen)), id: bus.s_axi_arid});
                total += int'(bus.s_axi_arlen) + 1;
                sent++;
            end
            if (prev_stall) begin
                n_tests++;
                if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rid !== prev_id || bus.s_axi_rdata !== prev_data || bus.s_axi_rlast !== prev_last) begin
                    n_fail++; $display("FAIL rand_r_stable: got v%b %h/%h want 1 %h/%h", bus.s_axi_rvalid, bus.s_axi_rid, bus.s_axi_rdata, prev_id, prev_data);
                end
            end
            if (bus.ram_rd_cmd_en && bus.ram_rd_cmd_ready) begin
                n_tests++;
                if (exp_cmd.size() == 0) begin
                    n_fail++; $display("FAIL rand_cmd_extra: got addr %h want no beat", bus.ram_rd_cmd_addr);
                end else begin
                    e = exp_cmd.pop_front();
                    if (bus.ram_rd_cmd_addr !== e.addr || bus.ram_rd_cmd_last !== e.last || bus.ram_rd_cmd_id !== e.id) begin
                        n_fail++; $display("FAIL rand_cmd: got %h/%b/%h want %h/%b/%h", bus.ram_rd_cmd_addr, bus.ram_rd_cmd_last, bus.ram_rd_cmd_id, e.addr, e.last, e.id);
                    end
                end
                pend.push_back('{id: bus.ram_rd_cmd_id, data: $urandom, last: bus.ram_rd_cmd_last});
            end
            if (bus.s_axi_rvalid && bus.s_axi_rready) begin
                n_tests++;
                rcount++;
                if (exp_r.size() == 0) begin
                    n_fail++; $display("FAIL rand_r_extra: got %h want no beat", bus.s_axi_rdata);
                end else begin
                    rr = exp_r.pop_front();
                    if (bus.s_axi_rid !== rr.id || bus.s_axi_rdata !== rr.data || bus.s_axi_rlast !== rr.last || bus.s_axi_rresp !== RESP_OKAY) begin
                        n_fail++; $display("FAIL rand_r: got %h/%h/%b/%b want %h/%h/%b/00", bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rlast, bus.s_axi_rresp, rr.id, rr.data, rr.last);
                    end
                end
            end
            resp_hs = bus.ram_rd_resp_valid && bus.ram_rd_resp_ready;
            if (resp_hs) exp_r.push_back(pend.pop_front());
            prev_stall = bus.s_axi_rvalid && !bus.s_axi_rready;
            prev_id = bus.s_axi_rid; prev_data = bus.s_axi_rdata; prev_last = bus.s_axi_rlast;
            tick();
            if (ar_hs) bus.s_axi_arvalid = 1'b0;
            if (!bus.s_axi_arvalid && sent < NB && $urandom_range(0, 3) == 0) begin
                pick = $urandom_range(0, 5);
                case (pick)
                    0: bus.s_axi_arlen = 8'd0;
                    1: bus.s_axi_arlen = 8'd1;
                    2: bus.s_axi_arlen = 8'd3;
                    3: bus.s_axi_arlen = 8'd7;
                    4: bus.s_axi_arlen = 8'd15;
                    default: bus.s_axi_arlen = 8'($urandom_range(0, 15));
                endcase
                bus.s_axi_araddr = 16'($urandom_range(0, 65535));
                bus.s_axi_arsize = 3'($urandom_range(0, 3));
                bus.s_axi_arburst = 2'($urandom_range(0, 3));
                bus.s_axi_arid = 8'($urandom_range(0, 255));
                bus.s_axi_arvalid = 1'b1;
            end
            bus.ram_rd_cmd_ready = ($urandom_range(0, 99) < 70);
            if (!(bus.ram_rd_resp_valid && !resp_hs)) begin
                bus.ram_rd_resp_valid = 1'b0;
                if (pend.size() > 0 && $urandom_range(0, 99) < 75) begin
                    p = pend[0];
                    bus.ram_rd_resp_id = p.id; bus.ram_rd_resp_data = p.data; bus.ram_rd_resp_last = p.last;
                    bus.ram_rd_resp_valid = 1'b1;
                end
            end
            bus.s_axi_rready = ($urandom_range(0, 99) < 60);
            done = (sent == NB) && !bus.s_axi_arvalid && exp_cmd.size() == 0 && pend.size() == 0 &&
                   exp_r.size() == 0 && !bus.s_axi_rvalid && !bus.ram_rd_cmd_en;
        end
        n_tests++; if (!done || rcount != total) begin
            n_fail++; $display("FAIL rand_complete: got %0d R beats of %0d done %b want all", rcount, total, done);
        end
        init_inputs();
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_clamp_reserved();
        test_r_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
